vote_ballot_collector: RTL and testbench
========================================

Name: vote_ballot_collector

Overview:
Upstream stage of the vote counter. Accepts one ballot per cycle over a valid/ready interface and tracks which voters have already voted. Assembles the 32-bit np, 8-bit vip and 1-bit vvip vectors, then freezes them and presents them with a level ballot_valid until the consumer acknowledges. The consumer is the combinational vote counter, which takes np/vip/vvip.

Parameters:
NP_N, 32, number of normal voters (ids 0..NP_N-1)
VIP_N, 8, number of VIP voters (ids NP_N..NP_N+VIP_N-1)
ID_W, 6, width of voter id
TIMEOUT, 255, idle cycles before auto-close (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  open a new session (honoured only in IDLE)
close  in  1  end the session early (honoured only in OPEN)
in_valid  in  1  ballot present
in_ready  out  1  collector accepts ballots (high only in OPEN)
in_id  in  ID_W  voter id: 0..31 np, 32..39 vip, 40 vvip
in_val  in  1  vote value, 1 = yes
np  out  NP_N  assembled normal votes
vip  out  VIP_N  assembled VIP votes
vvip  out  1  VVIP vote
ballot_valid  out  1  vectors frozen and complete (level)
ballot_ack  in  1  consumer has taken the vectors
voted_cnt  out  6  number of distinct voters accepted this session
dup_err  out  1  one-cycle pulse: repeat vote from an already-voted id
id_err  out  1  one-cycle pulse: id > 40

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high.
- Reset values:
  - state IDLE
  - np, vip, vvip, voted mask (41 bits) all 0
  - voted_cnt 0
  - in_ready, ballot_valid, dup_err, id_err all 0
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- FSM states: IDLE, OPEN, DONE.
- IDLE:
  - in_ready 0.
  - start=1 -> OPEN on the next edge. On that same edge np/vip/vvip, mask and voted_cnt clear to 0.
  - Vectors from the previous session remain readable until start.
- OPEN:
  - in_ready 1. A ballot is accepted when in_valid & in_ready.
  - in_id > 40 -> id_err pulses the following cycle; no state change.
  - mask[in_id]=1 -> dup_err pulses the following cycle. The first vote stands; the vector and count are unchanged.
  - Otherwise the vector bit takes in_val, mask[in_id] is set and voted_cnt increments, all on the same edge.
  - An accept that makes voted_cnt = 41 moves the FSM to DONE on that edge.
  - close=1 -> DONE on the next edge. If close and a valid accept occur in the same cycle, the ballot is recorded first, then DONE.
  - start in OPEN is ignored.
- DONE:
  - in_ready 0; ballot_valid 1.
  - Vectors are held constant; unvoted ids read as 0 (no).
  - ballot_ack=1 -> IDLE next edge; ballot_valid drops the same edge.
  - start and close in DONE are ignored.
- Latency: a ballot accepted at edge N is visible on np/vip/vvip after edge N. ballot_valid rises one edge after the closing event.
- Reset asserted mid-session: the session is abandoned immediately and all outputs return to reset values asynchronously.

Optional Feature:
Macro VOTE_COLLECTOR_TIMEOUT_EN.
- Defined:
  - A counter runs in OPEN. It clears on entry to OPEN and on every accepted, non-error ballot.
  - When it reaches TIMEOUT the FSM goes to DONE exactly as for close. TIMEOUT counts whole idle cycles.
  - If an accept and the terminal count coincide, the accept is recorded and DONE follows.
- Not defined: no counter is built; OPEN ends only on close or when all 41 have voted.
- Ports are identical in both builds.

Decomposition:
- Shared package vote_pkg holds:
  - FSM state encoding (IDLE/OPEN/DONE)
  - NP_BASE=0, VIP_BASE=32, VVIP_ID=40, VOTER_TOTAL=41
  - ID_W
- The vote counter shares the same package.
- One sub-module, vote_timeout_ctr (load/clear/terminal-count), is instantiated only under VOTE_COLLECTOR_TIMEOUT_EN.
- Id decode and mask logic stay in the top.

Test Plan:
1. Reset mid-OPEN after 5 ballots -> all outputs 0 immediately, state IDLE; start then reopens with voted_cnt=0.
2. start; ids 0..31 yes, 32..39 no, 40 yes (41 consecutive beats) -> DONE after the 41st accept; np=32'hFFFF_FFFF, vip=8'h00, vvip=1, voted_cnt=41, ballot_valid=1 until ballot_ack, then IDLE.
3. start; id 5 yes, id 5 no, id 45 -> np[5]=1 retained, dup_err pulses once, id_err pulses once, voted_cnt=1.
4. start; ids 0..9 yes, close asserted with a valid id 10 yes in the same cycle -> np=32'h0000_07FF, voted_cnt=11, ballot_valid next cycle; start during DONE ignored.
5. With VOTE_COLLECTOR_TIMEOUT_EN and TIMEOUT=4: start, one ballot, then idle -> DONE exactly 4 idle cycles after the last accept. Without the macro -> remains OPEN indefinitely.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the ballot collector and the vote counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vote_pkg;

  // Collector session states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Voter id map: 0..31 normal, 32..39 VIP, 40 VVIP
  localparam int NP_BASE     = 0;
  localparam int VIP_BASE    = 32;
  localparam int VVIP_ID     = 40;
  localparam int VOTER_TOTAL = 41;
  localparam int ID_W        = 6;

endpackage

// File: rtl/vote_timeout_ctr.sv
// Idle-cycle counter that flags when a session has been quiet for TIMEOUT cycles.
// Latency: tc asserts during the TIMEOUT-th idle cycle after the last clear.
// Backpressure: none; counts while enabled, saturates at terminal count.
module vote_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  // Terminal count: the cycle now ending is the TIMEOUT-th idle one
  assign tc = (cnt == W'(TIMEOUT - 1));

  // Count idle cycles, restart on clear, hold once terminal
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/vote_ballot_collector.sv
// Collects one ballot per cycle, rejects duplicates/bad ids, freezes np/vip/vvip for the counter.
// Latency: accepted ballot visible one edge later; ballot_valid rises one edge after session close.
// Backpressure: in_ready high only while OPEN; results held until ballot_ack. Option: VOTE_COLLECTOR_TIMEOUT_EN.
module vote_ballot_collector #(
  parameter int NP_N    = 32,
  parameter int VIP_N   = 8,
  parameter int ID_W    = vote_pkg::ID_W,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             close,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_id,
  input  logic             in_val,
  output logic [NP_N-1:0]  np,
  output logic [VIP_N-1:0] vip,
  output logic             vvip,
  output logic             ballot_valid,
  input  logic             ballot_ack,
  output logic [5:0]       voted_cnt,
  output logic             dup_err,
  output logic             id_err
);

  import vote_pkg::*;

  state_t                 state, state_nxt;
  logic [VOTER_TOTAL-1:0] vec;
  logic [VOTER_TOTAL-1:0] mask;
  logic                   accept, id_bad, is_dup, good_accept, last_vote, tmo_tc;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign accept      = in_valid & in_ready;
  assign id_bad      = (in_id > ID_W'(VVIP_ID));
  assign is_dup      = !id_bad && mask[in_id];
  assign good_accept = accept & !id_bad & !is_dup;
  assign last_vote   = (voted_cnt == 6'(VOTER_TOTAL - 1));

  assign in_ready     = (state == ST_OPEN);
  assign ballot_valid = (state == ST_DONE);
  assign np           = vec[NP_BASE +: NP_N];
  assign vip          = vec[VIP_BASE +: VIP_N];
  assign vvip         = vec[VVIP_ID];

`ifdef VOTE_COLLECTOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  // Idle timer restarts on entering OPEN and on every recorded ballot
  vote_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .W       (TO_W)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clear ((state != ST_OPEN) | good_accept),
    .en    (1'b1),
    .tc    (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Session sequencing: a ballot in the closing cycle is recorded by the datapath regardless
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_OPEN;
      ST_OPEN: if ((good_accept && last_vote) || close || tmo_tc) state_nxt = ST_DONE;
      ST_DONE: if (ballot_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ballot recording, duplicate tracking and one-cycle error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec       <= '0;
      mask      <= '0;
      voted_cnt <= '0;
      dup_err   <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      dup_err <= 1'b0;
      id_err  <= 1'b0;
      if (state == ST_IDLE && start) begin
        vec       <= '0;
        mask      <= '0;
        voted_cnt <= '0;
      end
      if (accept) begin
        if (id_bad) begin
          id_err <= 1'b1;
        end else if (is_dup) begin
          dup_err <= 1'b1;
        end else begin
          vec[in_id]  <= in_val;
          mask[in_id] <= 1'b1;
          voted_cnt   <= voted_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for vote_ballot_collector with a reference model and expected-result queue.
// Latency: checks one edge after each ballot; timeout scenario selected by VOTE_COLLECTOR_TIMEOUT_EN.
// Backpressure: ballots only driven while in_ready is expected high.
module tb_vote_ballot_collector;

  typedef struct {
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [5:0]  cnt;
    logic        dup;
    logic        ide;
    logic        rdy;
    logic        bv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, close, in_valid, in_val, ballot_ack;
  logic [5:0]  in_id;
  logic        in_ready, vvip, ballot_valid, dup_err, id_err;
  logic [31:0] np;
  logic [7:0]  vip;
  logic [5:0]  voted_cnt;

  int vectors = 0;
  int errors  = 0;

  exp_t        sb[$];
  logic [40:0] m_vec;
  logic [40:0] m_mask;
  int          m_cnt;

  vote_ballot_collector #(
    .NP_N(32), .VIP_N(8), .ID_W(6), .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .close        (close),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_id        (in_id),
    .in_val       (in_val),
    .np           (np),
    .vip          (vip),
    .vvip         (vvip),
    .ballot_valid (ballot_valid),
    .ballot_ack   (ballot_ack),
    .voted_cnt    (voted_cnt),
    .dup_err      (dup_err),
    .id_err       (id_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_vec  = '0;
    m_mask = '0;
    m_cnt  = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_np"}, np, 0);
    chk({tag, "_vip"}, vip, 0);
    chk({tag, "_vvip"}, vvip, 0);
    chk({tag, "_cnt"}, voted_cnt, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_bv"}, ballot_valid, 0);
    chk({tag, "_dup"}, dup_err, 0);
    chk({tag, "_ide"}, id_err, 0);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_np"}, np, e.np);
      chk({tag, "_vip"}, vip, e.vip);
      chk({tag, "_vvip"}, vvip, e.vvip);
      chk({tag, "_cnt"}, voted_cnt, e.cnt);
      chk({tag, "_dup"}, dup_err, e.dup);
      chk({tag, "_ide"}, id_err, e.ide);
      chk({tag, "_rdy"}, in_ready, e.rdy);
      chk({tag, "_bv"}, ballot_valid, e.bv);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    chk({tag, "_open_rdy"}, in_ready, 1);
    chk({tag, "_open_cnt"}, voted_cnt, 0);
    chk({tag, "_open_np"}, np, 0);
  endtask

  // Drive one ballot (optionally with close) and check the result one edge later
  task automatic send(input string tag, input int id, input bit val, input bit cls);
    exp_t e;
    chk({tag, "_pre_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_id    = 6'(id);
    in_val   = val;
    close    = cls;
    e.dup = 1'b0;
    e.ide = 1'b0;
    if (id > 40) begin
      e.ide = 1'b1;
    end else if (m_mask[id]) begin
      e.dup = 1'b1;
    end else begin
      m_mask[id] = 1'b1;
      m_vec[id]  = val;
      m_cnt++;
    end
    e.np   = m_vec[31:0];
    e.vip  = m_vec[39:32];
    e.vvip = m_vec[40];
    e.cnt  = 6'(m_cnt);
    e.bv   = cls || (m_cnt == 41);
    e.rdy  = !e.bv;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    close    = 1'b0;
    pop_compare(tag);
  endtask

  task automatic do_ack(input string tag);
    chk({tag, "_pre_bv"}, ballot_valid, 1);
    ballot_ack = 1'b1;
    step();
    ballot_ack = 1'b0;
    chk({tag, "_post_bv"}, ballot_valid, 0);
    chk({tag, "_post_rdy"}, in_ready, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; close = 1'b0; in_valid = 1'b0;
    in_id = '0; in_val = 1'b0; ballot_ack = 1'b0;
    model_clear();
    #2;
    chk_all_zero("rst0");
    #1 reset = 1'b0;
    step();
    chk("idle_rdy", in_ready, 0);

    // 1: reset in the middle of an open session
    do_start("t1");
    for (int i = 0; i < 5; i++) send("t1_b", i, 1'b1, 1'b0);
    chk("t1_cnt5", voted_cnt, 5);
    reset = 1'b1;
    #1;
    chk_all_zero("t1_rst");
    #2 reset = 1'b0;
    model_clear();
    step();
    chk("t1_idle_rdy", in_ready, 0);
    do_start("t1_re");

    // 2: full electorate closes the session
    reset = 1'b0;
    for (int i = 0; i < 32; i++) send("t2_np", i, 1'b1, 1'b0);
    for (int i = 32; i < 40; i++) send("t2_vip", i, 1'b0, 1'b0);
    send("t2_vvip", 40, 1'b1, 1'b0);
    chk("t2_np_all", np, 32'hFFFF_FFFF);
    chk("t2_vip_all", vip, 8'h00);
    chk("t2_cnt41", voted_cnt, 41);
    step();
    chk("t2_bv_hold", ballot_valid, 1);
    do_ack("t2_ack");
    chk("t2_np_kept", np, 32'hFFFF_FFFF);

    // 3: duplicate and out-of-range ids
    do_start("t3");
    send("t3_first", 5, 1'b1, 1'b0);
    send("t3_dup", 5, 1'b0, 1'b0);
    send("t3_badid", 45, 1'b1, 1'b0);
    step();
    chk("t3_dup_once", dup_err, 0);
    chk("t3_ide_once", id_err, 0);
    chk("t3_np5", np, 32'h0000_0020);
    chk("t3_cnt1", voted_cnt, 1);
    close = 1'b1;
    step();
    close = 1'b0;
    chk("t3_close_bv", ballot_valid, 1);
    do_ack("t3_ack");

    // 4: close coincides with a valid ballot; start ignored in DONE
    do_start("t4");
    for (int i = 0; i < 10; i++) send("t4_b", i, 1'b1, 1'b0);
    send("t4_close", 10, 1'b1, 1'b1);
    chk("t4_np", np, 32'h0000_07FF);
    chk("t4_cnt", voted_cnt, 11);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_start_ign_bv", ballot_valid, 1);
    chk("t4_start_ign_np", np, 32'h0000_07FF);
    chk("t4_start_ign_cnt", voted_cnt, 11);
    do_ack("t4_ack");

    // 5: idle behaviour after one ballot
    do_start("t5");
    send("t5_b", 3, 1'b1, 1'b0);
`ifdef VOTE_COLLECTOR_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t5_still_open", in_ready, 1);
    end
    step();
    chk("t5_timeout_bv", ballot_valid, 1);
    chk("t5_timeout_rdy", in_ready, 0);
    do_ack("t5_ack");
`else
    for (int k = 0; k < 20; k++) step();
    chk("t5_open_rdy", in_ready, 1);
    chk("t5_open_bv", ballot_valid, 0);
    close = 1'b1;
    step();
    close = 1'b0;
    do_ack("t5_ack");
`endif

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
